// File: rtl/types_pkg.sv
// Shared fixed-point and geometry types for the triangle pipeline.
// fixed_t is signed Q11.12; every stage imports these types.
package types_pkg;

   localparam int FIXED_FRAC_BITS = 12;
   localparam int FIXED_WIDTH     = 24;

   typedef logic signed [FIXED_WIDTH-1:0] fixed_t;

   localparam fixed_t FIXED_MAX = 24'sh7FFFFF;
   localparam fixed_t FIXED_MIN = 24'sh800000;

   typedef fixed_t [2:0] fixed3_t;

   typedef struct packed {
      fixed_t x;
      fixed_t y;
      fixed_t z;
   } point_t;

   typedef struct packed {
      point_t v0;
      point_t v1;
      point_t v2;
   } triangle_t;

   // rot[row][col]; output coordinate c uses row c.
   typedef struct packed {
      point_t             position;
      fixed3_t [2:0]      rot;
   } transform_t;

   typedef struct packed {
      triangle_t  triangle;
      transform_t transform;
   } pipeline_entry_t;

   typedef logic last_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_OUTPUT  = 2'd2
   } tt_state_e;

   function automatic fixed3_t point_to_vec(input point_t p);
      fixed3_t v;
      v[0] = p.x;
      v[1] = p.y;
      v[2] = p.z;
      return v;
   endfunction

endpackage

// File: rtl/fixed_dot3.sv
// Combinational 3-wide fixed-point dot product with a fixed-point offset:
// result = (a.b + offset<<FRAC_BITS) >>> FRAC_BITS, then clamped or wrapped to 24 bits.
module fixed_dot3
   import types_pkg::*;
#(
   parameter int FRAC_BITS = FIXED_FRAC_BITS,
   parameter bit SATURATE  = 1'b1
) (
   input  fixed3_t i_a,
   input  fixed3_t i_b,
   input  fixed_t  i_offset,
   output fixed_t  o_result
);

   localparam int PROD_W = 2 * FIXED_WIDTH;
   localparam int ACC_W  = PROD_W + 2;

   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(FIXED_MAX);
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(FIXED_MIN);

   logic signed [PROD_W-1:0] w_prod [3];
   logic signed [ACC_W-1:0]  w_acc;
   logic signed [ACC_W-1:0]  w_shifted;

   always_comb begin
      // NOTE: every signal assigned in an always_comb gets a value on every path, so no latch is inferred.
      w_acc = $signed({{(ACC_W-FIXED_WIDTH){i_offset[FIXED_WIDTH-1]}}, i_offset}) <<< FRAC_BITS;
      for (int k = 0; k < 3; k++) begin
         w_prod[k] = $signed(i_a[k]) * $signed(i_b[k]);
         w_acc     = w_acc + $signed({{(ACC_W-PROD_W){w_prod[k][PROD_W-1]}}, w_prod[k]});
      end
      // Arithmetic shift floors toward -inf, matching Q11.12 truncation.
      w_shifted = w_acc >>> FRAC_BITS;
      o_result  = w_shifted[FIXED_WIDTH-1:0];
      if (SATURATE) begin
         if (w_shifted > SAT_HI) begin
            o_result = FIXED_MAX;
         end else if (w_shifted < SAT_LO) begin
            o_result = FIXED_MIN;
         end
      end
   end

endmodule

// File: rtl/triangle_transform.sv
// Maps a model triangle to world space (v' = R*v + p) using one shared dot3 unit,
// stepping over the 9 output coordinates one per cycle.
module triangle_transform
   import types_pkg::*;
#(
   parameter int FRAC_BITS = FIXED_FRAC_BITS,
   parameter bit SATURATE  = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            triangle_tf_s_valid,
   output logic            triangle_tf_s_ready,
   input  pipeline_entry_t triangle_tf_s_data,
   input  last_t           triangle_tf_s_metadata,
   output logic            triangle_m_valid,
   input  logic            triangle_m_ready,
   output triangle_t       triangle_m_data,
   output last_t           triangle_m_metadata
);

   tt_state_e     r_state;
   triangle_t     r_tri;
   transform_t    r_tf;
   last_t         r_last;
   logic [1:0]    r_vtx;
   logic [1:0]    r_crd;
   fixed3_t [2:0] r_res;
   logic          r_m_valid;

   logic    w_accept;
   fixed3_t w_row;
   fixed3_t w_vec;
   fixed_t  w_offset;
   fixed_t  w_result;

   // Gated by rst so ready is low throughout the reset cycle itself.
   assign triangle_tf_s_ready = (r_state == ST_IDLE) && !rst;
   assign w_accept            = triangle_tf_s_valid && triangle_tf_s_ready;

   always_comb begin
      w_row    = r_tf.rot[0];
      w_offset = r_tf.position.x;
      case (r_crd)
         2'd1: begin
            w_row    = r_tf.rot[1];
            w_offset = r_tf.position.y;
         end
         2'd2: begin
            w_row    = r_tf.rot[2];
            w_offset = r_tf.position.z;
         end
         default: ;
      endcase
      case (r_vtx)
         2'd1:    w_vec = point_to_vec(r_tri.v1);
         2'd2:    w_vec = point_to_vec(r_tri.v2);
         default: w_vec = point_to_vec(r_tri.v0);
      endcase
   end

   fixed_dot3 #(
      .FRAC_BITS (FRAC_BITS),
      .SATURATE  (SATURATE)
   ) u_dot3 (
      .i_a      (w_row),
      .i_b      (w_vec),
      .i_offset (w_offset),
      .o_result (w_result)
   );

   // NOTE: the captured entry is pure datapath, qualified by the FSM, so it carries no reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_tri <= triangle_tf_s_data.triangle;
         r_tf  <= triangle_tf_s_data.transform;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         r_state   <= ST_IDLE;
         r_m_valid <= 1'b0;
         r_last    <= 1'b0;
         r_vtx     <= 2'd0;
         r_crd     <= 2'd0;
         r_res     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_last  <= triangle_tf_s_metadata;
                  r_vtx   <= 2'd0;
                  r_crd   <= 2'd0;
                  r_state <= ST_COMPUTE;
               end
            end
            ST_COMPUTE: begin
               r_res[r_vtx][r_crd] <= w_result;
               if (r_crd == 2'd2) begin
                  r_crd <= 2'd0;
                  if (r_vtx == 2'd2) begin
                     r_state   <= ST_OUTPUT;
                     r_m_valid <= 1'b1;
                  end else begin
                     r_vtx <= r_vtx + 2'd1;
                  end
               end else begin
                  r_crd <= r_crd + 2'd1;
               end
            end
            ST_OUTPUT: begin
               if (triangle_m_ready) begin
                  r_state   <= ST_IDLE;
                  r_m_valid <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_m_valid <= 1'b0;
            end
         endcase
      end
   end

   assign triangle_m_valid    = r_m_valid;
   assign triangle_m_metadata = r_last;
   assign triangle_m_data     = '{
      v0: '{x: r_res[0][0], y: r_res[0][1], z: r_res[0][2]},
      v1: '{x: r_res[1][0], y: r_res[1][1], z: r_res[1][2]},
      v2: '{x: r_res[2][0], y: r_res[2][1], z: r_res[2][2]}
   };

endmodule

// File: tb/tb_triangle_transform.sv
// Self-checking bench: a saturating and a wrapping instance share stimulus and are
// compared against an integer-arithmetic reference of v' = R*v + p.
module tb_triangle_transform;
   import types_pkg::*;

   localparam fixed_t ONE = 24'sh001000;

   logic            clk = 1'b0;
   logic            rst;
   logic            s_valid;
   pipeline_entry_t s_data;
   last_t           s_meta;
   logic            m_ready;

   logic      s_ready,  w_s_ready;
   logic      m_valid,  w_m_valid;
   triangle_t m_data,   w_m_data;
   last_t     m_meta,   w_m_meta;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   triangle_transform #(.FRAC_BITS(12), .SATURATE(1'b1)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .triangle_tf_s_valid    (s_valid),
      .triangle_tf_s_ready    (s_ready),
      .triangle_tf_s_data     (s_data),
      .triangle_tf_s_metadata (s_meta),
      .triangle_m_valid       (m_valid),
      .triangle_m_ready       (m_ready),
      .triangle_m_data        (m_data),
      .triangle_m_metadata    (m_meta)
   );

   triangle_transform #(.FRAC_BITS(12), .SATURATE(1'b0)) dut_wrap (
      .clk                    (clk),
      .rst                    (rst),
      .triangle_tf_s_valid    (s_valid),
      .triangle_tf_s_ready    (w_s_ready),
      .triangle_tf_s_data     (s_data),
      .triangle_tf_s_metadata (s_meta),
      .triangle_m_valid       (w_m_valid),
      .triangle_m_ready       (m_ready),
      .triangle_m_data        (w_m_data),
      .triangle_m_metadata    (w_m_meta)
   );

   // Reference: plain 64-bit integer arithmetic, floor division by 2^12, then clamp or wrap.
   function automatic triangle_t model(input pipeline_entry_t e, input bit sat);
      fixed_t    r [3][3];
      fixed_t    v [3][3];
      fixed_t    p [3];
      fixed_t    o [3][3];
      point_t    pts [3];
      longint    s;
      triangle_t t;
      pts[0] = e.triangle.v0;
      pts[1] = e.triangle.v1;
      pts[2] = e.triangle.v2;
      p[0] = e.transform.position.x;
      p[1] = e.transform.position.y;
      p[2] = e.transform.position.z;
      for (int i = 0; i < 3; i++) begin
         v[i][0] = pts[i].x;
         v[i][1] = pts[i].y;
         v[i][2] = pts[i].z;
         for (int k = 0; k < 3; k++) r[i][k] = e.transform.rot[i][k];
      end
      for (int i = 0; i < 3; i++) begin
         for (int c = 0; c < 3; c++) begin
            s = longint'(p[c]) * 64'sd4096;
            for (int k = 0; k < 3; k++) s = s + longint'(r[c][k]) * longint'(v[i][k]);
            s = s >>> 12;
            if (sat && s > 64'sd8388607)  s = 64'sd8388607;
            if (sat && s < -64'sd8388608) s = -64'sd8388608;
            o[i][c] = fixed_t'(s);
         end
      end
      t.v0 = '{x: o[0][0], y: o[0][1], z: o[0][2]};
      t.v1 = '{x: o[1][0], y: o[1][1], z: o[1][2]};
      t.v2 = '{x: o[2][0], y: o[2][1], z: o[2][2]};
      return t;
   endfunction

   function automatic fixed_t rnd_small();
      return fixed_t'(int'($urandom_range(0, 131071)) - 65536);
   endfunction

   function automatic point_t rnd_point(input bit full);
      point_t p;
      p.x = full ? fixed_t'($urandom) : rnd_small();
      p.y = full ? fixed_t'($urandom) : rnd_small();
      p.z = full ? fixed_t'($urandom) : rnd_small();
      return p;
   endfunction

   function automatic pipeline_entry_t diag_entry(input fixed_t d);
      pipeline_entry_t e;
      e = '0;
      for (int i = 0; i < 3; i++) e.transform.rot[i][i] = d;
      return e;
   endfunction

   task automatic send(input pipeline_entry_t e, input last_t l, input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (s_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (s_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_ready_timeout got=%b exp=1", name, s_ready);
      end
      s_valid = 1'b1;
      s_data  = e;
      s_meta  = l;
      @(posedge clk);
      #1 s_valid = 1'b0;
   endtask

   // Counts cycles from the accepting edge; the first negedge seen belongs to cycle 1.
   task automatic wait_output(input string name);
      int cyc;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (m_valid !== 1'b1 && cyc < 40);
      checks++;
      if (cyc != 10 || m_valid !== 1'b1) begin
         failures++;
         $display("FAIL %s_latency got=%0d valid=%b exp=10", name, cyc, m_valid);
      end
   endtask

   task automatic check_result(input pipeline_entry_t e, input last_t l, input string name);
      triangle_t exp_sat, exp_wrap;
      exp_sat  = model(e, 1'b1);
      exp_wrap = model(e, 1'b0);
      checks++;
      if (m_data !== exp_sat) begin
         failures++;
         $display("FAIL %s_sat_data got=%h exp=%h", name, m_data, exp_sat);
      end
      checks++;
      if (w_m_valid !== 1'b1 || w_m_data !== exp_wrap) begin
         failures++;
         $display("FAIL %s_wrap_data got=%h valid=%b exp=%h", name, w_m_data, w_m_valid, exp_wrap);
      end
      checks++;
      if (m_meta !== l || w_m_meta !== l) begin
         failures++;
         $display("FAIL %s_last got=%b/%b exp=%b", name, m_meta, w_m_meta, l);
      end
   endtask

   task automatic retire(input string name);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1 || w_s_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_retire got valid=%b ready=%b/%b exp valid=0 ready=1",
                  name, m_valid, s_ready, w_s_ready);
      end
   endtask

   task automatic run_one(input pipeline_entry_t e, input last_t l, input string name);
      send(e, l, name);
      wait_output(name);
      check_result(e, l, name);
      retire(name);
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      s_meta  = 1'b0;
      m_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || m_meta !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got ready=%b valid=%b data=%h last=%b exp all zero",
                  s_ready, m_valid, m_data, m_meta);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (s_ready !== 1'b1 || w_s_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready got=%b/%b exp=1", s_ready, w_s_ready);
      end
   endtask

   task automatic test_identity();
      pipeline_entry_t e;
      point_t          exp_v0;
      e = diag_entry(ONE);
      e.triangle.v0 = '{x: 24'sh001000, y: 24'sh002000, z: 24'sh003000};
      e.triangle.v1 = rnd_point(1'b0);
      e.triangle.v2 = rnd_point(1'b0);
      exp_v0 = e.triangle.v0;
      send(e, 1'b1, "identity");
      wait_output("identity");
      check_result(e, 1'b1, "identity");
      checks++;
      if (m_data.v0 !== exp_v0 || m_data.v1 !== e.triangle.v1 || m_data.v2 !== e.triangle.v2) begin
         failures++;
         $display("FAIL identity_passthrough got=%h exp=%h", m_data, e.triangle);
      end
      retire("identity");
   endtask

   task automatic test_offset();
      pipeline_entry_t e;
      e = diag_entry(ONE);
      e.transform.position = '{x: 24'sh002000, y: -24'sh001000, z: 24'sh000000};
      e.triangle.v0 = '{x: 24'sh001000, y: 24'sh002000, z: 24'sh003000};
      e.triangle.v1 = rnd_point(1'b0);
      e.triangle.v2 = rnd_point(1'b0);
      send(e, 1'b0, "offset");
      wait_output("offset");
      check_result(e, 1'b0, "offset");
      checks++;
      if (m_data.v0 !== point_t'{x: 24'sh003000, y: 24'sh001000, z: 24'sh003000}) begin
         failures++;
         $display("FAIL offset_v0 got=%h exp=003000001000003000", m_data.v0);
      end
      retire("offset");
   endtask

   task automatic test_rot90();
      pipeline_entry_t e;
      e = '0;
      e.transform.rot[0][1] = -ONE;
      e.transform.rot[1][0] = ONE;
      e.transform.rot[2][2] = ONE;
      e.triangle.v0 = '{x: ONE, y: 24'sh0, z: 24'sh0};
      e.triangle.v1 = '{x: 24'sh000800, y: 24'sh000800, z: 24'sh0};
      e.triangle.v2 = rnd_point(1'b0);
      send(e, 1'b0, "rot90");
      wait_output("rot90");
      check_result(e, 1'b0, "rot90");
      checks++;
      if (m_data.v0 !== point_t'{x: 24'sh0, y: ONE, z: 24'sh0} ||
          m_data.v1 !== point_t'{x: -24'sh000800, y: 24'sh000800, z: 24'sh0}) begin
         failures++;
         $display("FAIL rot90_vertices got v0=%h v1=%h exp v0=000000001000000000 v1=fff800000800000000",
                  m_data.v0, m_data.v1);
      end
      retire("rot90");
   endtask

   task automatic test_saturate();
      pipeline_entry_t e;
      fixed_t          big;
      big = 24'sh07F000;
      e = diag_entry(big);
      e.triangle.v0 = '{x: big, y: big, z: big};
      e.triangle.v1 = '{x: -big, y: -big, z: -big};
      e.triangle.v2 = '{x: ONE, y: -ONE, z: 24'sh0};
      send(e, 1'b1, "saturate");
      wait_output("saturate");
      check_result(e, 1'b1, "saturate");
      checks++;
      if (m_data.v0.x !== FIXED_MAX || m_data.v1.x !== FIXED_MIN) begin
         failures++;
         $display("FAIL saturate_clamp got=%h/%h exp=7fffff/800000", m_data.v0.x, m_data.v1.x);
      end
      checks++;
      if (w_m_data.v0.x !== 24'shF01000 || w_m_data.v1.x !== 24'sh0FF000) begin
         failures++;
         $display("FAIL saturate_wrap got=%h/%h exp=f01000/0ff000", w_m_data.v0.x, w_m_data.v1.x);
      end
      retire("saturate");
   endtask

   task automatic test_random();
      pipeline_entry_t e;
      bit              full;
      for (int n = 0; n < 12; n++) begin
         full = (n % 3) == 2;
         e.triangle.v0 = rnd_point(full);
         e.triangle.v1 = rnd_point(full);
         e.triangle.v2 = rnd_point(full);
         e.transform.position = rnd_point(full);
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               e.transform.rot[r][c] = full ? fixed_t'($urandom) : rnd_small();
         run_one(e, last_t'($urandom_range(0, 1)), $sformatf("random%0d", n));
      end
   endtask

   task automatic test_backpressure();
      pipeline_entry_t a, b;
      triangle_t       exp_a;
      bit              stable;
      a = diag_entry(ONE);
      a.triangle.v0 = rnd_point(1'b0);
      a.triangle.v1 = rnd_point(1'b0);
      a.triangle.v2 = rnd_point(1'b0);
      a.transform.position = rnd_point(1'b0);
      b = diag_entry(-ONE);
      b.triangle.v0 = rnd_point(1'b0);
      b.triangle.v1 = rnd_point(1'b0);
      b.triangle.v2 = rnd_point(1'b0);
      exp_a = model(a, 1'b1);
      m_ready = 1'b0;
      send(a, 1'b1, "bp_first");
      wait_output("bp_first");
      s_valid = 1'b1;
      s_data  = b;
      s_meta  = 1'b0;
      stable  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m_valid !== 1'b1 || m_data !== exp_a || m_meta !== 1'b1 || s_ready !== 1'b0)
            stable = 1'b0;
      end
      checks++;
      if (!stable) begin
         failures++;
         $display("FAIL bp_hold got valid=%b ready=%b data=%h exp valid=1 ready=0 data=%h",
                  m_valid, s_ready, m_data, exp_a);
      end
      m_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", m_valid, s_ready);
      end
      @(posedge clk);
      #1 s_valid = 1'b0;
      wait_output("bp_second");
      check_result(b, 1'b0, "bp_second");
      retire("bp_second");
   endtask

   task automatic test_reset_midflight();
      pipeline_entry_t e;
      bit              quiet;
      e = diag_entry(ONE);
      e.triangle.v0 = rnd_point(1'b0);
      e.triangle.v1 = rnd_point(1'b0);
      e.triangle.v2 = rnd_point(1'b0);
      send(e, 1'b1, "rst_mid");
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (s_ready !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_ready_in_reset got=%b exp=0", s_ready);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (m_valid !== 1'b0 || m_data !== '0 || s_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_state got valid=%b ready=%b data=%h exp valid=0 ready=1 data=0",
                  m_valid, s_ready, m_data);
      end
      quiet = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (m_valid !== 1'b0 || w_m_valid !== 1'b0) quiet = 1'b0;
      end
      checks++;
      if (!quiet) begin
         failures++;
         $display("FAIL rst_mid_no_output got valid=%b exp=0", m_valid);
      end
      e.triangle.v0 = rnd_point(1'b0);
      e.transform.position = rnd_point(1'b0);
      run_one(e, 1'b0, "rst_mid_next");
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   initial begin
      test_reset();
      test_identity();
      test_offset();
      test_rot90();
      test_saturate();
      test_random();
      test_backpressure();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/triangle_transform.md
Name: triangle_transform

Overview:
- Downstream neighbour of the pipeline head.
- Consumes the triangle+transform stream: each entry is one model triangle paired with one scene instance transform, plus a last flag.
- Outputs the triangle with all three vertices mapped to world space: v' = R·v + p, with R a 3x3 rotation matrix and p a position.
- One shared 3-wide dot-product unit is time-multiplexed over the 9 output coordinates. The result feeds the projection stage.

Parameters:
- FRAC_BITS, 12, fractional bits of fixed_t. Must match the package constant.
- SATURATE, 1, 1 = clamp results to the fixed_t range; 0 = wrap (keep low 24 bits).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- triangle_tf_s_valid  in  1  input entry valid
- triangle_tf_s_ready  out  1  block can accept an entry
- triangle_tf_s_data  in  pipeline_entry_t  {triangle_t triangle; transform_t transform}
- triangle_tf_s_metadata  in  last_t  last-triangle-of-scene flag
- triangle_m_valid  out  1  transformed triangle valid
- triangle_m_ready  in  1  downstream accepts
- triangle_m_data  out  triangle_t  transformed vertices v0..v2
- triangle_m_metadata  out  last_t  passthrough of the input last flag

Interface rule (already decided): one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset values:
  - triangle_tf_s_ready=0 during the reset cycle, 1 in the first cycle after.
  - triangle_m_valid=0, triangle_m_data=0, triangle_m_metadata=0.
  - State is IDLE.
- Handshake: a transfer occurs on a rising edge with valid&&ready. The master never drops valid, or changes data, before the transfer.
- FSM states:
  - IDLE: s_ready=1. On an input transfer, latch triangle, transform and last; clear idx (0..8); go to COMPUTE.
  - COMPUTE: s_ready=0. Each cycle computes output coordinate idx:
    - vertex = idx/3, coord = idx%3.
    - result = dot(R[coord][0..2], v[vertex]) + p[coord].
    - Write the result into the output triangle register; idx++.
    - After idx=8, go to OUTPUT.
  - OUTPUT: m_valid=1, data and metadata stable. On m_valid&&m_ready, go to IDLE (m_valid=0 next cycle).
- Latency: input accepted at edge T; m_valid=1 in the cycle after edge T+9. Minimum spacing between accepted inputs is 11 cycles (downstream always ready).
- Arithmetic:
  - fixed_t is signed 24-bit, Q11.12.
  - Products are full 48-bit signed.
  - Sum of the three products plus (p sign-extended << FRAC_BITS) uses a 50-bit accumulator.
  - Arithmetic shift right by FRAC_BITS (truncation toward −inf).
  - SATURATE=1: values >0x7FFFFF clamp to 0x7FFFFF; values <−0x800000 clamp to 0x800000.
  - SATURATE=0: keep the low 24 bits.
- Boundary conditions:
  - Input valid during COMPUTE/OUTPUT is ignored (ready=0); the upstream entry is held.
  - m_ready held low: stay in OUTPUT indefinitely, outputs unchanged.
  - rst asserted in any state: next cycle is IDLE, partial results are discarded, m_valid=0, no output is produced for the in-flight entry.
  - last flag: copied unchanged; it has no effect on the FSM.

Decomposition:
- types_pkg holds:
  - fixed_t, FIXED_FRAC_BITS=12
  - point_t {x,y,z}
  - triangle_t {v0,v1,v2}
  - transform_t {point_t position; fixed_t rot[3][3]}
  - pipeline_entry_t, last_t
  - FIXED_MAX, FIXED_MIN
- Sub-module fixed_dot3: combinational; inputs a[3], b[3], offset; output saturated fixed_t result. Instantiated once; the FSM muxes row/vertex into it.

Test Plan:
- Identity R (diag 0x001000), p=0, v0=(1.0,2.0,3.0) -> same vertices out; m_valid rises exactly 10 cycles after the accepting edge; last=1 passes through.
- Identity R, p=(0x002000,−0x001000,0) -> every vertex offset by (+2.0,−1.0,0).
- R = 90° about Z (rows (0,−1,0),(1,0,0),(0,0,1)), v=(1.0,0,0) -> (0,1.0,0); v=(0x000800,0x000800,0) -> (−0x000800,0x000800,0).
- R diag 0x07F000, v=(0x07F000,…), SATURATE=1 -> x=0x7FFFFF; negative equivalent -> 0x800000; with SATURATE=0 the low 24 bits are kept.
- Hold m_ready=0 for 20 cycles with a second input pending -> output stable, s_ready=0 throughout; release -> first triangle accepted, second accepted the next cycle.
- Assert rst at COMPUTE idx=4 -> no output ever appears for that entry; the next entry processes correctly with 10-cycle latency.
